// File: rtl/conv_result_collector.sv
// Collects K row sums per beat into a total convolution sum, flags occupancy against
// a threshold, drops horizontal fill columns and queues results in a FWFT output FIFO.
module conv_result_collector #(
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned IMG_WIDTH    = 64,
  parameter int unsigned FIFO_DEPTH   = 8,
  localparam int unsigned SUM_WIDTH   = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE,
  localparam int unsigned ACC_WIDTH   = SUM_WIDTH + $clog2(KERNEL_SIZE),
  localparam int unsigned CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [SUM_WIDTH*KERNEL_SIZE-1:0] rowSums_in,
  input  logic                            rowSums_valid,
  input  logic [ACC_WIDTH-1:0]            threshold,
  output logic [ACC_WIDTH-1:0]            out_data,
  output logic                            out_occupied,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overflow,
  output logic [CNT_WIDTH-1:0]            fifo_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_FILL = COL_W'(KERNEL_SIZE - 1);

  typedef struct packed {
    logic [ACC_WIDTH-1:0] acc;
    logic                 occ;
    logic                 last;
  } entry_t;

  // Stage 1: sum and threshold compare
  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                 occ_d, occ_q;
  logic                 s1_valid_d, s1_valid_q;

  // Tag stage: column bookkeeping, fill drop and line-end marking
  logic [COL_W-1:0] col_d, col_q;
  logic             push_d, push_q;
  entry_t           entry_d, entry_q;

  // Output FIFO
  logic [PTR_W-1:0]     wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_d, rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_d, count_q;
  logic                 overflow_d, overflow_q;
  entry_t               mem_q [FIFO_DEPTH];
  entry_t               head;
  logic                 full, pop, wr_en;

  always_comb begin
    acc_d = '0;
    for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
      acc_d = acc_d + ACC_WIDTH'(rowSums_in[r*SUM_WIDTH +: SUM_WIDTH]);
    end
    occ_d      = (acc_d >= threshold);
    s1_valid_d = rowSums_valid;
  end

  always_comb begin
    col_d = col_q;
    if (s1_valid_q) begin
      col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
    end
    push_d        = s1_valid_q && (col_q >= COL_FILL);
    entry_d.acc   = acc_q;
    entry_d.occ   = occ_q;
    entry_d.last  = (col_q == COL_LAST);
  end

  assign full  = (count_q == CNT_WIDTH'(FIFO_DEPTH));
  assign pop   = (count_q != '0) && out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign wr_en = push_q && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_q && full && !pop);
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q      <= '0;
      occ_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      col_q      <= '0;
      push_q     <= 1'b0;
      entry_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      occ_q      <= occ_d;
      s1_valid_q <= s1_valid_d;
      col_q      <= col_d;
      push_q     <= push_d;
      entry_q    <= entry_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= entry_q;
  end

  // Head fields are gated by valid so reset forces them to zero without clearing storage.
  assign head         = mem_q[rd_ptr_q];
  assign out_valid    = (count_q != '0);
  assign out_data     = out_valid ? head.acc : '0;
  assign out_occupied = out_valid && head.occ;
  assign out_last     = out_valid && head.last;
  assign overflow     = overflow_q;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: fill drop, latency, threshold edge,
// backpressure/overflow, full push+pop, width/wrap and mid-line reset.
module tb_conv_result_collector;

  localparam int unsigned K     = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned WW    = 8;
  localparam int unsigned IMG   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SW    = DW + WW + K;
  localparam int unsigned AW    = SW + $clog2(K);
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned MAXV  = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic [SW*K-1:0] row_sums;
  logic          row_valid;
  logic [AW-1:0] threshold;
  logic [AW-1:0] out_data;
  logic          out_occupied, out_last, out_valid, out_ready, overflow;
  logic [CW-1:0] fifo_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  conv_result_collector #(
    .KERNEL_SIZE (K),
    .DATA_WIDTH  (DW),
    .WEIGHT_WIDTH(WW),
    .IMG_WIDTH   (IMG),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rowSums_in   (row_sums),
    .rowSums_valid(row_valid),
    .threshold    (threshold),
    .out_data     (out_data),
    .out_occupied (out_occupied),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input int unsigned a, input int unsigned b, input int unsigned c);
    row_valid = v;
    row_sums  = {SW'(c), SW'(b), SW'(a)};
    step();
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    row_valid = 1'b0;
    row_sums  = '0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn      = 1'b0;
    row_valid = 1'b0;
    row_sums  = '0;
    threshold = '0;
    out_ready = 1'b0;
    do_reset();

    check("rst_valid", 32'(out_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_data",  32'(out_data), 0);
    check("rst_occ",   32'(out_occupied), 0);
    check("rst_last",  32'(out_last), 0);

    // Fill and latency: 8 beats of {1,2,3}, first two dropped
    threshold = AW'(5);
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) cyc(1'b1, 1, 2, 3);
      else       cyc(1'b0, 0, 0, 0);
      check($sformatf("fill_valid_e%0d", k), 32'(out_valid), (k >= 4 && k <= 9) ? 1 : 0);
      if (k >= 4 && k <= 9) begin
        check($sformatf("fill_data_e%0d", k), 32'(out_data), 6);
        check($sformatf("fill_occ_e%0d", k),  32'(out_occupied), 1);
        check($sformatf("fill_last_e%0d", k), 32'(out_last), (k == 9) ? 1 : 0);
      end
    end

    // Threshold edge
    do_reset();
    threshold = AW'(5);
    out_ready = 1'b1;
    cyc(1'b1, 0, 0, 0);
    cyc(1'b1, 0, 0, 0);
    cyc(1'b1, 1, 2, 2);
    cyc(1'b1, 1, 1, 2);
    cyc(1'b0, 0, 0, 0);
    check("thr_eq_valid", 32'(out_valid), 1);
    check("thr_eq_data",  32'(out_data), 5);
    check("thr_eq_occ",   32'(out_occupied), 1);
    cyc(1'b0, 0, 0, 0);
    check("thr_lt_valid", 32'(out_valid), 1);
    check("thr_lt_data",  32'(out_data), 4);
    check("thr_lt_occ",   32'(out_occupied), 0);

    // Backpressure and overflow
    do_reset();
    threshold = AW'(5);
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, (k >= 2) ? 10 * (k - 1) : 0, 0, 0);
      if (k == 4) begin
        check("bp_count_e4", 32'(fifo_count), 1);
        check("bp_head_e4",  32'(out_data), 10);
      end
      if (k == 7) begin
        check("bp_count_e7", 32'(fifo_count), 4);
        check("bp_ovf_e7",   32'(overflow), 0);
        check("bp_head_e7",  32'(out_data), 10);
      end
    end
    cyc(1'b0, 0, 0, 0);
    check("bp_ovf_e8",   32'(overflow), 1);
    check("bp_count_e8", 32'(fifo_count), 4);
    cyc(1'b0, 0, 0, 0);
    check("bp_head_e9",  32'(out_data), 10);
    check("bp_occ_e9",   32'(out_occupied), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_pop%0d_valid", i), 32'(out_valid), 1);
      check($sformatf("bp_pop%0d_data", i),  32'(out_data), 10 * (i + 1));
      cyc(1'b0, 0, 0, 0);
    end
    check("bp_drained_valid", 32'(out_valid), 0);
    check("bp_drained_count", 32'(fifo_count), 0);
    check("bp_ovf_sticky",    32'(overflow), 1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    threshold = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) cyc(1'b1, (k >= 2) ? (k - 1) : 0, 0, 0);
    check("fpp_count_e7", 32'(fifo_count), 4);
    check("fpp_head_e7",  32'(out_data), 1);
    out_ready = 1'b1;
    cyc(1'b0, 0, 0, 0);
    check("fpp_count_e8", 32'(fifo_count), 4);
    check("fpp_ovf_e8",   32'(overflow), 0);
    check("fpp_head_e8",  32'(out_data), 2);
    cyc(1'b0, 0, 0, 0);
    check("fpp_count_e9", 32'(fifo_count), 4);
    check("fpp_ovf_e9",   32'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fpp_drain%0d_data", i), 32'(out_data), 3 + i);
      check($sformatf("fpp_drain%0d_last", i), 32'(out_last), (i == 3) ? 1 : 0);
      cyc(1'b0, 0, 0, 0);
    end
    check("fpp_empty_valid", 32'(out_valid), 0);
    check("fpp_ovf_final",   32'(overflow), 0);

    // Max-width sums across two lines: column wrap and repeated fill drop
    do_reset();
    threshold = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) cyc(1'b1, MAXV, MAXV, MAXV);
      else        cyc(1'b0, 0, 0, 0);
      if (k >= 2 && ((k - 2) % 8) >= 2) begin
        check($sformatf("wrap_valid_e%0d", k), 32'(out_valid), 1);
        check($sformatf("wrap_data_e%0d", k),  32'(out_data), 1572861);
        check($sformatf("wrap_last_e%0d", k),  32'(out_last), (((k - 2) % 8) == 7) ? 1 : 0);
      end else begin
        check($sformatf("wrap_valid_e%0d", k), 32'(out_valid), 0);
      end
    end

    // Reset mid-line with two entries queued
    do_reset();
    threshold = '0;
    out_ready = 1'b0;
    cyc(1'b1, 0, 0, 0);
    cyc(1'b1, 0, 0, 0);
    cyc(1'b1, 7, 0, 0);
    cyc(1'b1, 8, 0, 0);
    cyc(1'b0, 0, 0, 0);
    cyc(1'b0, 0, 0, 0);
    check("mrst_pre_count", 32'(fifo_count), 2);
    check("mrst_pre_head",  32'(out_data), 7);
    #2;
    rstn = 1'b0;
    #1;
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_count", 32'(fifo_count), 0);
    check("mrst_data",  32'(out_data), 0);
    check("mrst_occ",   32'(out_occupied), 0);
    check("mrst_last",  32'(out_last), 0);
    check("mrst_ovf",   32'(overflow), 0);
    row_valid = 1'b1;
    row_sums  = {SW'(0), SW'(0), SW'(9)};
    step();
    row_valid = 1'b0;
    rstn      = 1'b1;
    out_ready = 1'b1;
    cyc(1'b1, 11, 0, 0);
    cyc(1'b1, 12, 0, 0);
    cyc(1'b1, 13, 0, 0);
    check("mrst_f2_valid", 32'(out_valid), 0);
    cyc(1'b0, 0, 0, 0);
    check("mrst_f3_valid", 32'(out_valid), 0);
    cyc(1'b0, 0, 0, 0);
    check("mrst_f4_valid", 32'(out_valid), 1);
    check("mrst_f4_data",  32'(out_data), 13);
    cyc(1'b0, 0, 0, 0);
    check("mrst_f5_valid", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
